// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// Memory access stage: issues data-bus requests for loads/stores and
// produces the registered writeback bundle with load extension.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] ex_result_mem_i,
  input  logic [31:0] reg2_data_mem_i,
  input  logic [2:0]  funct3_mem_i,
  input  logic        mem_read_mem_i,
  input  logic        mem_write_mem_i,
  input  logic        reg_write_mem_i,
  input  logic [1:0]  mem_to_reg_mem_i,
  input  logic [4:0]  rd_addr_mem_i,
  input  logic [31:0] pc_plus_4_mem_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_reg_write_o,
  output logic        mem_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d, wbrd_q, wbrd_d;
  logic        rw_q, rw_d;
  logic        wbv_q, wbv_d, wbrw_q, wbrw_d, err_q, err_d;
  logic [31:0] wbd_q, wbd_d;

  logic [1:0]  size, off;
  logic        is_mem, bad_f3, misal, err;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, alu_sel, sh_b, sh_h, ld_data;

  assign size   = funct3_mem_i[1:0];
  assign off    = ex_result_mem_i[1:0];
  assign is_mem = mem_read_mem_i | mem_write_mem_i;
  assign bad_f3 = (size == 2'b11) ||
                  (funct3_mem_i[2] && (mem_write_mem_i || size == 2'b10));
  assign misal  = (size == 2'b01 && off[0]) ||
                  (size == 2'b10 && off != 2'b00);
  assign err    = is_mem &&
                  ((mem_read_mem_i && mem_write_mem_i) || bad_f3 || misal);
  assign alu_sel = (mem_to_reg_mem_i == 2'b10) ? pc_plus_4_mem_i
                                               : ex_result_mem_i;

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = reg2_data_mem_i;
    unique case (1'b1)
      size == 2'b00: begin
        be_n    = 4'b0001 << off;
        wdata_n = {4{reg2_data_mem_i[7:0]}};
      end
      size == 2'b01: begin
        be_n    = 4'b0011 << off;
        wdata_n = {2{reg2_data_mem_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign sh_b = dmem_rdata_i >> {off_q, 3'b000};
  assign sh_h = dmem_rdata_i >> {off_q[1], 4'b0000};

  always_comb begin
    ld_data = dmem_rdata_i;
    unique case (1'b1)
      f3_q == 3'b000: ld_data = {{24{sh_b[7]}}, sh_b[7:0]};
      f3_q == 3'b001: ld_data = {{16{sh_h[15]}}, sh_h[15:0]};
      f3_q == 3'b100: ld_data = {24'd0, sh_b[7:0]};
      f3_q == 3'b101: ld_data = {16'd0, sh_h[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    wbv_d   = 1'b0;
    wbd_d   = wbd_q;
    wbrd_d  = wbrd_q;
    wbrw_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (valid_i) begin
        if (!is_mem || err) begin
          wbv_d  = 1'b1;
          wbd_d  = err ? 32'd0 : alu_sel;
          wbrd_d = rd_addr_mem_i;
          wbrw_d = !err && reg_write_mem_i && rd_addr_mem_i != 5'd0;
          err_d  = err;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = mem_write_mem_i;
          addr_d  = {ex_result_mem_i[31:2], 2'b00};
          be_d    = be_n;
          wdata_d = wdata_n;
          f3_d    = funct3_mem_i;
          off_d   = off;
          rd_d    = rd_addr_mem_i;
          rw_d    = reg_write_mem_i;
        end
      end
      REQ: if (dmem_gnt_i) begin
        req_d = 1'b0;
        we_d  = 1'b0;
        if (we_q) begin
          state_d = IDLE;
          wbv_d   = 1'b1;
          wbd_d   = 32'd0;
          wbrd_d  = rd_q;
        end else begin
          state_d = RESP;
        end
      end
      RESP: if (dmem_rvalid_i) begin
        state_d = IDLE;
        wbv_d   = 1'b1;
        wbd_d   = ld_data;
        wbrd_d  = rd_q;
        wbrw_d  = rw_q && rd_q != 5'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      wbv_q   <= 1'b0;
      wbd_q   <= 32'd0;
      wbrd_q  <= 5'd0;
      wbrw_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
      wbrd_q  <= wbrd_d;
      wbrw_q  <= wbrw_d;
      err_q   <= err_d;
    end
  end

  assign stall_o        = (state_q != IDLE);
  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;
  assign wb_valid_o     = wbv_q;
  assign wb_data_o      = wbd_q;
  assign wb_rd_addr_o   = wbrd_q;
  assign wb_reg_write_o = wbrw_q;
  assign mem_err_o      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// Bench for mem_stage: directed vector table, hand sequences for
// reset/back-to-back corners, and randomized ops against a reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst, valid, mr, mw, rw, gnt, rvalid;
  logic [31:0] exr, r2, pc, rdata;
  logic [2:0]  f3;
  logic [1:0]  m2r;
  logic [4:0]  rd;
  logic        stall, req, we, wbv, wbrw, err;
  logic [31:0] addr, wdata, wbd;
  logic [3:0]  be;
  logic [4:0]  wbrd;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid),
    .ex_result_mem_i(exr), .reg2_data_mem_i(r2),
    .funct3_mem_i(f3), .mem_read_mem_i(mr), .mem_write_mem_i(mw),
    .reg_write_mem_i(rw), .mem_to_reg_mem_i(m2r),
    .rd_addr_mem_i(rd), .pc_plus_4_mem_i(pc),
    .stall_o(stall), .dmem_req_o(req), .dmem_we_o(we),
    .dmem_addr_o(addr), .dmem_be_o(be), .dmem_wdata_o(wdata),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .wb_valid_o(wbv), .wb_data_o(wbd), .wb_rd_addr_o(wbrd),
    .wb_reg_write_o(wbrw), .mem_err_o(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rd_en, wr_en;
    logic [2:0]  f3;
    logic [31:0] addr, data;
    logic [1:0]  m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] pc, rdata;
    int          gdly, rdly;
    logic        e_req, e_err, e_rw;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_wb;
  } vec_t;

  function automatic vec_t mk(
    input logic r, w, input logic [2:0] fn, input logic [31:0] a, d,
    input logic [1:0] sel, input logic wr, input logic [4:0] dst,
    input logic [31:0] p, rdat, input int g, rl,
    input logic ereq, eerr, erw, input logic [3:0] ebe,
    input logic [31:0] ewd, ewb);
    vec_t v;
    v.rd_en = r;  v.wr_en = w;  v.f3 = fn;  v.addr = a;  v.data = d;
    v.m2r = sel;  v.rw = wr;  v.rd = dst;  v.pc = p;  v.rdata = rdat;
    v.gdly = g;  v.rdly = rl;  v.e_req = ereq;  v.e_err = eerr;
    v.e_rw = erw;  v.e_be = ebe;  v.e_wdata = ewd;  v.e_wb = ewb;
    return v;
  endfunction

  // Reference: derives expectations from the ISA load/store rules.
  function automatic vec_t model(input vec_t v);
    int sz, off, nb;
    bit uns, mem, bad;
    logic [31:0] raw, mask;
    sz  = int'(v.f3[1:0]);
    uns = v.f3[2];
    off = int'(v.addr % 4);
    mem = v.rd_en || v.wr_en;
    bad = (v.rd_en && v.wr_en) || sz == 3 || (uns && (v.wr_en || sz == 2))
          || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
    v.e_err = mem && bad;
    v.e_req = mem && !bad;
    v.e_be = 4'd0;  v.e_wdata = 32'd0;  v.e_wb = 32'd0;  v.e_rw = 1'b0;
    nb = 1 << sz;
    if (!mem) begin
      v.e_wb = (v.m2r == 2'b10) ? v.pc : v.addr;
      v.e_rw = v.rw && v.rd != 5'd0;
    end else if (v.e_req && v.wr_en) begin
      v.e_be = 4'((1 << nb) - 1) << off;
      if (sz == 0) v.e_wdata = (v.data % 256) * 32'h01010101;
      else if (sz == 1) v.e_wdata = (v.data % 65536) * 32'h00010001;
      else v.e_wdata = v.data;
    end else if (v.e_req) begin
      raw = v.rdata >> (8 * off);
      if (sz == 2) v.e_wb = raw;
      else begin
        mask = (nb == 1) ? 32'hFF : 32'hFFFF;
        v.e_wb = raw & mask;
        if (!uns && v.e_wb > mask / 2) v.e_wb = v.e_wb - mask - 1;
      end
      v.e_rw = v.rw && v.rd != 5'd0;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string t);
    chk({t, "/stall_pre"}, 32'(stall), 32'd0);
    exr = v.addr;  r2 = v.data;  f3 = v.f3;  mr = v.rd_en;  mw = v.wr_en;
    rw = v.rw;  m2r = v.m2r;  rd = v.rd;  pc = v.pc;  valid = 1'b1;
    step;
    valid = 1'b0;  mr = 1'b0;  mw = 1'b0;
    if (!v.e_req) begin
      chk({t, "/no_req"}, 32'(req), 32'd0);
      chk({t, "/stall"}, 32'(stall), 32'd0);
      chk({t, "/wbv"}, 32'(wbv), 32'd1);
      chk({t, "/err"}, 32'(err), 32'(v.e_err));
      chk({t, "/wbrw"}, 32'(wbrw), 32'(v.e_rw));
      chk({t, "/wbrd"}, 32'(wbrd), 32'(v.rd));
      if (!v.e_err) chk({t, "/wbd"}, wbd, v.e_wb);
    end else begin
      chk({t, "/req"}, 32'(req), 32'd1);
      chk({t, "/we"}, 32'(we), 32'(v.wr_en));
      chk({t, "/addr"}, addr, {v.addr[31:2], 2'b00});
      chk({t, "/stall"}, 32'(stall), 32'd1);
      chk({t, "/wbv0"}, 32'(wbv), 32'd0);
      if (v.wr_en) begin
        chk({t, "/be"}, 32'(be), 32'(v.e_be));
        chk({t, "/wdata"}, wdata, v.e_wdata);
      end
      for (int i = 0; i < v.gdly; i++) begin
        rvalid = 1'($urandom_range(0, 1));
        rdata  = $urandom;
        step;
        rvalid = 1'b0;
        chk({t, "/req_hold"}, 32'(req), 32'd1);
        chk({t, "/addr_hold"}, addr, {v.addr[31:2], 2'b00});
        chk({t, "/wbv_hold"}, 32'(wbv), 32'd0);
        if (v.wr_en) begin
          chk({t, "/be_hold"}, 32'(be), 32'(v.e_be));
          chk({t, "/wdata_hold"}, wdata, v.e_wdata);
        end
      end
      gnt = 1'b1;
      step;
      gnt = 1'b0;
      chk({t, "/req_drop"}, 32'(req), 32'd0);
      if (v.wr_en) begin
        chk({t, "/st_wbv"}, 32'(wbv), 32'd1);
        chk({t, "/st_wbrw"}, 32'(wbrw), 32'd0);
        chk({t, "/st_err"}, 32'(err), 32'd0);
        chk({t, "/st_stall"}, 32'(stall), 32'd0);
      end else begin
        chk({t, "/resp_stall"}, 32'(stall), 32'd1);
        chk({t, "/resp_wbv"}, 32'(wbv), 32'd0);
        for (int i = 0; i < v.rdly; i++) begin
          step;
          chk({t, "/resp_wait"}, 32'(wbv), 32'd0);
        end
        rdata  = v.rdata;
        rvalid = 1'b1;
        step;
        rvalid = 1'b0;
        chk({t, "/ld_wbv"}, 32'(wbv), 32'd1);
        chk({t, "/ld_wbd"}, wbd, v.e_wb);
        chk({t, "/ld_wbrw"}, 32'(wbrw), 32'(v.e_rw));
        chk({t, "/ld_wbrd"}, 32'(wbrd), 32'(v.rd));
        chk({t, "/ld_err"}, 32'(err), 32'd0);
        chk({t, "/ld_stall"}, 32'(stall), 32'd0);
      end
    end
    step;
    chk({t, "/pulse_end"}, 32'(wbv), 32'd0);
    chk({t, "/rw_idle"}, 32'(wbrw), 32'd0);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1'b1;  valid = 1'b0;  mr = 1'b0;  mw = 1'b0;  rw = 1'b0;
    gnt = 1'b0;  rvalid = 1'b0;  exr = '0;  r2 = '0;  pc = '0;
    rdata = '0;  f3 = '0;  m2r = '0;  rd = '0;

    step;
    step;
    chk("rst/req", 32'(req), 32'd0);
    chk("rst/we", 32'(we), 32'd0);
    chk("rst/be", 32'(be), 32'd0);
    chk("rst/addr", addr, 32'd0);
    chk("rst/wdata", wdata, 32'd0);
    chk("rst/wbv", 32'(wbv), 32'd0);
    chk("rst/wbrw", 32'(wbrw), 32'd0);
    chk("rst/wbd", wbd, 32'd0);
    chk("rst/wbrd", 32'(wbrd), 32'd0);
    chk("rst/err", 32'(err), 32'd0);
    chk("rst/stall", 32'(stall), 32'd0);
    rst = 1'b0;
    step;

    tbl.push_back(mk(0,0,3'd0,32'h12345678,0,2'b00,1,5'd5,32'h1004,0,0,0,
                     0,0,1,4'h0,0,32'h12345678));
    tbl.push_back(mk(0,0,3'd0,32'h40,0,2'b10,1,5'd1,32'h2008,0,0,0,
                     0,0,1,4'h0,0,32'h2008));
    tbl.push_back(mk(0,0,3'd0,32'hDEAD,0,2'b11,1,5'd0,0,0,0,0,
                     0,0,0,4'h0,0,32'hDEAD));
    tbl.push_back(mk(0,1,3'd0,32'h103,32'hAB,2'b00,0,5'd0,0,0,3,0,
                     1,0,0,4'b1000,32'hABABABAB,0));
    tbl.push_back(mk(0,1,3'd1,32'h102,32'h1234BEEF,2'b00,0,5'd0,0,0,1,0,
                     1,0,0,4'b1100,32'hBEEFBEEF,0));
    tbl.push_back(mk(0,1,3'd2,32'h204,32'hA5A5,2'b00,0,5'd0,0,0,0,0,
                     1,0,0,4'b1111,32'h0000A5A5,0));
    tbl.push_back(mk(1,0,3'd0,32'h101,0,2'b01,1,5'd9,0,32'h0000F000,0,1,
                     1,0,1,4'h0,0,32'hFFFFFFF0));
    tbl.push_back(mk(1,0,3'd4,32'h101,0,2'b01,1,5'd9,0,32'h0000F000,1,0,
                     1,0,1,4'h0,0,32'h000000F0));
    tbl.push_back(mk(1,0,3'd5,32'h102,0,2'b01,1,5'd10,0,32'h80010000,2,0,
                     1,0,1,4'h0,0,32'h00008001));
    tbl.push_back(mk(1,0,3'd1,32'h102,0,2'b01,1,5'd10,0,32'h80010000,0,0,
                     1,0,1,4'h0,0,32'hFFFF8001));
    tbl.push_back(mk(1,0,3'd2,32'h102,0,2'b01,1,5'd4,0,0,0,0,
                     0,1,0,4'h0,0,0));
    tbl.push_back(mk(0,1,3'd1,32'h101,0,2'b00,1,5'd4,0,0,0,0,
                     0,1,0,4'h0,0,0));
    tbl.push_back(mk(1,0,3'd3,32'h100,0,2'b01,1,5'd4,0,0,0,0,
                     0,1,0,4'h0,0,0));
    tbl.push_back(mk(1,1,3'd2,32'h100,0,2'b01,1,5'd4,0,0,0,0,
                     0,1,0,4'h0,0,0));
    tbl.push_back(mk(1,0,3'd2,32'h300,0,2'b01,1,5'd31,0,32'h76543210,0,2,
                     1,0,1,4'h0,0,32'h76543210));
    tbl.push_back(mk(0,1,3'd4,32'h100,0,2'b00,1,5'd4,0,0,0,0,
                     0,1,0,4'h0,0,0));
    tbl.push_back(mk(1,0,3'd2,32'h400,0,2'b01,1,5'd0,0,32'h11112222,0,0,
                     1,0,0,4'h0,0,32'h11112222));
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // rvalid while idle must not retire anything
    rvalid = 1'b1;
    step;
    rvalid = 1'b0;
    chk("idle_rvalid/wbv", 32'(wbv), 32'd0);

    // reset while waiting in RESP abandons the load
    exr = 32'h500;  f3 = 3'd2;  mr = 1'b1;  rw = 1'b1;  rd = 5'd6;
    valid = 1'b1;
    step;
    valid = 1'b0;  mr = 1'b0;  gnt = 1'b1;
    step;
    gnt = 1'b0;
    chk("rst_resp/stall_pre", 32'(stall), 32'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_resp/stall", 32'(stall), 32'd0);
    chk("rst_resp/wbv", 32'(wbv), 32'd0);
    rvalid = 1'b1;  rdata = 32'hFFFF0000;
    step;
    rvalid = 1'b0;
    chk("rst_resp/late_rvalid", 32'(wbv), 32'd0);
    chk("rst_resp/idle", 32'(stall), 32'd0);

    // reset while in REQ drops the bus request
    exr = 32'h600;  r2 = 32'h77;  f3 = 3'd2;  mw = 1'b1;  valid = 1'b1;
    step;
    valid = 1'b0;  mw = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_req/req", 32'(req), 32'd0);
    chk("rst_req/be", 32'(be), 32'd0);
    gnt = 1'b1;
    step;
    gnt = 1'b0;
    chk("rst_req/late_gnt", 32'(wbv), 32'd0);

    // LW followed by ADD held during the stall
    exr = 32'h200;  f3 = 3'd2;  mr = 1'b1;  rw = 1'b1;  rd = 5'd3;
    m2r = 2'b01;  valid = 1'b1;
    step;
    exr = 32'h55;  mr = 1'b0;  rd = 5'd7;  m2r = 2'b00;
    chk("b2b/stall_req", 32'(stall), 32'd1);
    gnt = 1'b1;
    step;
    gnt = 1'b0;
    chk("b2b/stall_resp", 32'(stall), 32'd1);
    chk("b2b/no_early_add", 32'(wbv), 32'd0);
    rvalid = 1'b1;  rdata = 32'hCAFEBABE;
    step;
    rvalid = 1'b0;
    chk("b2b/lw_wbv", 32'(wbv), 32'd1);
    chk("b2b/lw_wbd", wbd, 32'hCAFEBABE);
    chk("b2b/lw_rd", 32'(wbrd), 32'd3);
    step;
    valid = 1'b0;
    chk("b2b/add_wbv", 32'(wbv), 32'd1);
    chk("b2b/add_wbd", wbd, 32'h55);
    chk("b2b/add_rd", 32'(wbrd), 32'd7);
    step;
    chk("b2b/add_once", 32'(wbv), 32'd0);

    for (int n = 0; n < 250; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      v.rd_en = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
      v.wr_en = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
      v.f3    = (kind == 3) ? 3'($urandom) : 3'($urandom_range(0, 2))
                | ((kind == 1 && $urandom_range(0, 1) == 1) ? 3'd4 : 3'd0);
      v.addr  = $urandom;
      v.data  = $urandom;
      v.m2r   = (v.rd_en || v.wr_en) ? 2'b01
              : ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b11);
      if (!v.rd_en && !v.wr_en && $urandom_range(0, 2) == 0) v.m2r = 2'b00;
      v.rw    = 1'($urandom);
      v.rd    = 5'($urandom);
      v.pc    = $urandom;
      v.rdata = $urandom;
      v.gdly  = int'($urandom_range(0, 3));
      v.rdly  = int'($urandom_range(0, 3));
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 valid_i  in  1  EX/MEM slot holds a valid instruction.
REQ-004 ex_result_mem_i  in  32  ALU result; byte address for loads/stores.
REQ-005 reg2_data_mem_i  in  32  store data, forwarded rs2.
REQ-006 funct3_mem_i  in  3  load/store width and sign code.
REQ-007 mem_read_mem_i / mem_write_mem_i  in  1 each  load / store request.
REQ-008 reg_write_mem_i  in  1  instruction writes rd.
REQ-009 mem_to_reg_mem_i  in  2  writeback source: 00 ALU, 01 memory, 10 pc+4, 11 ALU.
REQ-010 rd_addr_mem_i  in  5  destination register.
REQ-011 pc_plus_4_mem_i  in  32  link value.
REQ-012 stall_o  out  1  hold EX/MEM inputs stable; stall_o = (state != IDLE).
REQ-013 dmem_req_o, dmem_we_o  out  1 each  registered bus request and write flag.
REQ-014 dmem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 dmem_be_o  out  4  byte enables; dmem_wdata_o  out  32  lane-replicated store data.
REQ-016 dmem_gnt_i, dmem_rvalid_i  in  1 each  request accepted / read data valid.
REQ-017 dmem_rdata_i  in  32  read word.
REQ-018 wb_valid_o  out  1  one-cycle pulse per retired instruction.
REQ-019 wb_data_o  out  32, wb_rd_addr_o  out  5, wb_reg_write_o  out  1  registered writeback fields.
REQ-020 mem_err_o  out  1  pulse with wb_valid_o on misaligned access, illegal funct3, or read and write both high.

Function
REQ-021 FSM SHALL have states IDLE, REQ, RESP; inputs are accepted only in IDLE when valid_i=1.
REQ-022 Non-memory op in IDLE SHALL pulse wb_valid_o the next cycle with the data selected per REQ-009 (latency 1); state stays IDLE.
REQ-023 Legal memory op in IDLE SHALL capture address, data, funct3, rd, and controls, and go to REQ with dmem_req_o=1 the next cycle.
REQ-024 In REQ, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, and dmem_wdata_o SHALL stay constant until dmem_gnt_i=1.
REQ-025 Store grant SHALL go to IDLE and pulse wb_valid_o with wb_reg_write_o=0; load grant SHALL go to RESP.
REQ-026 In RESP, dmem_req_o=0; dmem_rvalid_i=1 SHALL go to IDLE and pulse wb_valid_o with extended load data; dmem_rvalid_i SHALL be ignored in IDLE and REQ.
REQ-027 Load extension by funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; byte/half lane selected by addr[1:0].
REQ-028 Store byte enables: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; wdata byte/half replicated to all lanes.
REQ-029 Misaligned (half with addr[0]=1, word with addr[1:0]!=0), illegal funct3, or read&&write SHALL issue no bus request, pulse wb_valid_o and mem_err_o next cycle, and force wb_reg_write_o=0.
REQ-030 wb_reg_write_o SHALL be 0 whenever wb_valid_o=0, and for rd_addr=0.

Reset
REQ-031 rst SHALL force IDLE, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0, wb_valid_o=0, wb_reg_write_o=0, wb_data_o=0, wb_rd_addr_o=0, mem_err_o=0; a reset during REQ or RESP SHALL abandon the transaction, and any later rvalid is ignored.

Verification
REQ-032 ADD result 0x12345678, rd=5 -> next cycle wb_valid_o=1, wb_data_o=0x12345678, wb_rd_addr_o=5, stall_o never 1.
REQ-033 SB addr 0x103, data 0xAB, gnt delayed 3 cycles -> req held 3 cycles, be=4'b1000, wdata=0xABABABAB, addr=0x100, then wb_valid_o with wb_reg_write_o=0.
REQ-034 LB addr 0x101, rdata 0x0000F000 -> wb_data_o=0xFFFFFFF0; LBU same -> 0x000000F0; LHU addr 0x102, rdata 0x80010000 -> 0x00008001.
REQ-035 LW addr 0x102 -> no dmem_req_o, mem_err_o=1, wb_reg_write_o=0, stall_o stays 0.
REQ-036 rst asserted in RESP, rvalid one cycle after rst drops -> no wb_valid_o, state IDLE.
REQ-037 Back-to-back LW then ADD, ADD held while stall_o=1 -> ADD retires exactly once, one cycle after LW writeback.
